// File: rtl/auto_scale_formatter.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding a 4-digit auto-ranging window
// with decimal-point placement; digit outputs update only when a conversion completes.
module auto_scale_formatter #(
    parameter int W    = 20,
    parameter int D    = 7,
    parameter int FRAC = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] bin_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [4:0]   in0_o,
    output logic [4:0]   in1_o,
    output logic [4:0]   in2_o,
    output logic [4:0]   in3_o
);

    localparam int CW = $clog2(W);
    localparam int IW = $clog2(D);

    typedef enum logic [1:0] {IDLE, CONVERT, SCALE} state_t;

    state_t           state_reg;
    logic [W-1:0]     bin_reg;
    logic [D*4-1:0]   bcd_reg;
    logic [D*4-1:0]   bcd_adj;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [4:0]       out_reg [4];

    logic [3:0]       digit   [D];
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    win_idx [4];
    logic [4:0]       win_out [4];

    // Per-nibble add-3 correction applied before every shift.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_nibble
            assign digit[gi] = bcd_reg[gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Window top is the highest nonzero digit, but never below the units digit.
    always_comb begin
        top_idx = '0;
        for (int i = 1; i < D; i++) begin
            if (digit[i] != 4'd0) top_idx = IW'(i);
        end
        if (top_idx < IW'(FRAC)) top_idx = IW'(FRAC);
        for (int j = 0; j < 4; j++) begin
            win_idx[j] = top_idx - IW'(3 - j);
            win_out[j] = {(win_idx[j] != IW'(FRAC)), 4'd0};
            for (int k = 0; k < D; k++) begin
                if (win_idx[j] == IW'(k)) win_out[j][3:0] = digit[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            out_reg[3] <= 5'h00;
            out_reg[2] <= 5'h10;
            out_reg[1] <= 5'h10;
            out_reg[0] <= 5'h10;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        bin_reg   <= bin_i;
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                    if (cnt_reg == CW'(W - 1)) begin
                        state_reg <= SCALE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                SCALE: begin
                    for (int j = 0; j < 4; j++) out_reg[j] <= win_out[j];
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign in0_o  = out_reg[0];
    assign in1_o  = out_reg[1];
    assign in2_o  = out_reg[2];
    assign in3_o  = out_reg[3];

endmodule

// File: tb/tb_auto_scale_formatter.sv
// Directed bench for auto_scale_formatter: reset values, scaling cases, latency,
// ignored start, mid-conversion reset and back-to-back operation.
module tb_auto_scale_formatter;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic [19:0] bin_i;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  in0_o, in1_o, in2_o, in3_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [19:0] DISP_RST  = {5'h00, 5'h10, 5'h10, 5'h10};
    localparam logic [19:0] DISP_1234 = {5'h01, 5'h12, 5'h13, 5'h14};
    localparam logic [19:0] DISP_5678 = {5'h15, 5'h06, 5'h17, 5'h18};
    localparam logic [19:0] DISP_1048 = {5'h11, 5'h10, 5'h14, 5'h08};

    auto_scale_formatter #(.W(20), .D(7), .FRAC(3)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .in0_o   (in0_o),
        .in1_o   (in1_o),
        .in2_o   (in2_o),
        .in3_o   (in3_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [19:0] disp();
        return {in3_o, in2_o, in1_o, in0_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done_o; n is the number of edges after the accept edge.
    task automatic wait_done(output int n);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                n = c;
                break;
            end
        end
    endtask

    // Accepts one value, checks latency, result, busy and single-cycle done.
    task automatic run_conv(input string tag, input logic [19:0] value, input logic [19:0] exp_disp);
        int n;
        start_i = 1'b1;
        bin_i   = value;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        bin_i   = '0;
        check({tag, "_busy_hi"}, busy_o, 1);
        wait_done(n);
        check({tag, "_latency"}, n, 21);
        check({tag, "_disp"}, disp(), exp_disp);
        check({tag, "_busy_lo"}, busy_o, 0);
        @(posedge clk_i); #1;
        check({tag, "_done_pulse"}, done_o, 0);
        $display("conv %s value=%0d disp=%05h latency=%0d", tag, value, disp(), n);
    endtask

    initial begin
        int n;
        int dones;
        int hold_ok;
        rst_ni  = 1'b1;
        start_i = 1'b0;
        bin_i   = '0;

        // Asynchronous reset between edges.
        #3 rst_ni = 1'b0;
        #1;
        check("rst_disp", disp(), DISP_RST);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        $display("reset disp=%05h busy=%0b", disp(), busy_o);
        #18 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_conv("zero", 20'd0, DISP_RST);
        run_conv("v1234", 20'd1234, DISP_1234);
        run_conv("v56789", 20'd56789, DISP_5678);
        run_conv("v1048575", 20'd1048575, DISP_1048);

        // A start during CONVERT must be ignored.
        start_i = 1'b1;
        bin_i   = 20'd1234;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        bin_i   = 20'd9;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n = 0;
        for (int c = 6; c <= 40; c++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                n = c;
                break;
            end
        end
        check("ign_latency", n, 21);
        check("ign_disp", disp(), DISP_1234);
        check("ign_busy", busy_o, 0);
        dones = 0;
        repeat (30) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
            if (busy_o) dones++;
        end
        check("ign_no_extra", dones, 0);
        $display("conv ignored_start disp=%05h latency=%0d", disp(), n);

        run_conv("v56789b", 20'd56789, DISP_5678);

        // Reset in the middle of CONVERT.
        start_i = 1'b1;
        bin_i   = 20'd1048575;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_disp", disp(), DISP_RST);
        check("mid_rst_busy", busy_o, 0);
        #20 rst_ni = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_hold", disp(), DISP_RST);
        $display("conv mid_reset disp=%05h dones=%0d", disp(), dones);
        run_conv("after_rst", 20'd1234, DISP_1234);

        // Back-to-back with start held high; second value presented after the first accept.
        run_conv("b2b_prep", 20'd56789, DISP_5678);
        start_i = 1'b1;
        bin_i   = 20'd1234;
        @(posedge clk_i); #1;
        bin_i = 20'd56789;
        wait_done(n);
        check("b2b1_latency", n, 21);
        check("b2b1_disp", disp(), DISP_1234);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        bin_i   = '0;
        check("b2b2_accept", busy_o, 1);
        n = 0;
        hold_ok = 1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                n = c;
                break;
            end
            if (disp() !== DISP_1234) hold_ok = 0;
        end
        check("b2b_hold", hold_ok, 1);
        check("b2b2_latency", n, 21);
        check("b2b2_disp", disp(), DISP_5678);
        $display("conv back_to_back disp=%05h latency=%0d", disp(), n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/auto_scale_formatter.md
# auto_scale_formatter

Converts a binary measurement into four auto-scaled display digits for the 4-digit seven-segment time multiplexer that follows it. The input is a fixed-point value in thousandths, for example a frequency in mHz. The block performs a sequential binary-to-BCD conversion (shift-add-3). It then selects the four most significant meaningful digits and places the decimal point. Outputs are registered and hold steady between conversions, so the display never shows partial results.

## Interface
- `W`, default 20: binary input width.
- `D`, default 7: BCD digit count. The parameter constraint is 10^D > 2^W.
- `FRAC`, default 3: number of fractional decimal digits in the input. The parameter constraint is 3 ≤ FRAC ≤ D-1.
- `clk_i`, input, 1 bit: single clock domain.
- `rst_ni`, input, 1 bit: reset, asynchronous and active-low.
- `start_i`, input, 1 bit: request conversion. Sampled only in IDLE.
- `bin_i`, input, W bits: value to convert. Captured on the edge that accepts `start_i`.
- `busy_o`, output, 1 bit: high while a conversion is in progress.
- `done_o`, output, 1 bit: one-cycle pulse when the digit outputs are updated.
- `in0_o`…`in3_o`, output, 5 bits each: `[3:0]` is the BCD digit and `[4]` is the decimal point. `in3_o` is the leftmost digit.
- Decimal point polarity: active-low, so `0` means lit.

## Operation
- FSM states are IDLE, CONVERT and SCALE.
- **IDLE → CONVERT**
  - Condition: `start_i` = 1.
  - Load the shift register with `bin_i`, clear the BCD register (D×4 bits) and clear the bit counter.
- **CONVERT**
  - Runs for W cycles.
  - Each cycle, every BCD nibble ≥ 5 gets +3, then the combined {BCD, bin} register shifts left by 1.
  - After the W-th shift, go to SCALE.
- **SCALE**
  - Takes one cycle, then returns to IDLE.
  - Let `m` be the index of the highest nonzero digit, with `m` = 0 if the value is zero.
  - The window top is `t = max(m, FRAC)`.
  - Load the outputs: `in3_o`=d[t], `in2_o`=d[t-1], `in1_o`=d[t-2], `in0_o`=d[t-3].
  - Set the DP bit to 0 on the output carrying d[FRAC] and to 1 on all others. When `t-3 > FRAC`, no displayed digit is d[FRAC] and all DP bits are 1.
  - Pulse `done_o`.
- Leading zeros are not blanked. With FRAC=3 the window always includes d[3].
- Digits below the window are truncated, not rounded.
- `start_i` in CONVERT or SCALE is ignored. It is neither queued nor used to restart.
- `bin_i` is don't-care except on the accepting edge.
- The outputs change only in SCALE. `in*_o` hold their last values at all other times.

## Timing
- **Reset** (`rst_ni` = 0, asynchronous, takes effect immediately):
  - State goes to IDLE; `busy_o`=0, `done_o`=0.
  - `in3_o`=5'b0_0000 (digit 0, DP lit); `in2_o`..`in0_o`=5'b1_0000. The display reads "0.000".
  - Internal registers are cleared.
- **Reset mid-operation:** the conversion is aborted and the outputs return to the reset values. No `done_o` pulse is produced.
- **Accept:** `start_i` is accepted on clock edge k in IDLE. `busy_o` goes high after edge k.
- **Conversion:** the CONVERT shifts occur on edges k+1 … k+W.
- **Completion:** SCALE completes on edge k+W+1, with the following results after that edge:
  - `in*_o` take their new values.
  - `done_o`=1 for exactly one cycle.
  - `busy_o`=0.
- **Latency and throughput:**
  - Accept to `done_o` is W+1 cycles, which is 21 for W=20.
  - Back-to-back: a new `start_i` is accepted on edge k+W+2 at the earliest, because the FSM is in IDLE in the cycle where `done_o` is high. Throughput is W+2 cycles per conversion.
- **Width rules:**
  - The BCD register is D×4 bits and the add-3 is applied per nibble before each shift.
  - With the 10^D > 2^W constraint, the BCD register cannot overflow.

## Test plan
Defaults W=20, D=7, FRAC=3 for all cases.

- **Reset state:** assert `rst_ni`=0 asynchronously between edges.
  - Required: outputs change immediately to `in3_o`=5'h00, `in2_o`..`in0_o`=5'h10, `busy_o`=0.
- **Zero:** `bin_i`=0 → "0.000".
  - Required: `in3_o`=5'h00, `in2_o`=5'h10, `in1_o`=5'h10, `in0_o`=5'h10.
  - Required: `done_o` is exactly 21 cycles after the accept edge.
- **Values 1234, 56789 and 1048575:**
  - `bin_i`=1234 → "1.234": `in3_o`=5'h01, `in2_o`=5'h12, `in1_o`=5'h13, `in0_o`=5'h14.
  - `bin_i`=56789 → "56.78": `in3_o`=5'h15, `in2_o`=5'h06, `in1_o`=5'h17, `in0_o`=5'h18.
  - `bin_i`=1048575 → "1048.": `in3_o`=5'h11, `in2_o`=5'h10, `in1_o`=5'h14, `in0_o`=5'h08.
- **Ignored start:**
  - Stimulus: pulse `start_i` with `bin_i`=9 at cycle 5 of a 1234 conversion.
  - Required: exactly one `done_o` and the "1.234" result. `busy_o` falls on schedule.
- **Reset mid-CONVERT:**
  - Stimulus: start a 1048575 conversion, then drop `rst_ni` at cycle 10 of CONVERT.
  - Required: outputs go to the reset values and no `done_o` occurs.
  - Then, after release, start 1234 → required: correct "1.234" after 21 cycles.
- **Back-to-back:**
  - Stimulus: 1234 then 56789, with the second `start_i` held high continuously.
  - Required: the second accept occurs on the first cycle after `done_o`. Outputs hold "1.234" until the second `done_o`, then show "56.78".
